// File: rtl/hvsync_decode_pkg.sv
// Shared types and constants for the hsync/vsync timing-recovery receiver.
package hvsync_decode_pkg;

  // Default width of every counter and measurement output.
  localparam int unsigned DefaultW = 12;

  // Reference 480x272 panel geometry.
  localparam int unsigned PanelHTotal  = 544;
  localparam int unsigned PanelHActive = 480;
  localparam int unsigned PanelVTotal  = 314;
  localparam int unsigned PanelVActive = 272;

  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StLocked
  } state_e;

endpackage

// File: rtl/hvsync_decode_if.sv
// Video timing input and recovered coordinate/geometry outputs.
interface hvsync_decode_if
  import hvsync_decode_pkg::*;
#(
  parameter int unsigned W = DefaultW
) ();

  logic         hsync_in;
  logic         vsync_in;
  logic         de_in;
  logic         de_out;
  logic [W-1:0] hpos;
  logic [W-1:0] vpos;
  logic         newline;
  logic         newframe;
  logic [W-1:0] h_total;
  logic [W-1:0] h_active;
  logic [W-1:0] v_total;
  logic [W-1:0] v_active;
  logic         locked;
  logic         lost;

  // Source side: drives the raw timing, observes recovered results.
  modport master (
    output hsync_in, vsync_in, de_in,
    input  de_out, hpos, vpos, newline, newframe,
    input  h_total, h_active, v_total, v_active, locked, lost
  );

  // Decoder side.
  modport slave (
    input  hsync_in, vsync_in, de_in,
    output de_out, hpos, vpos, newline, newframe,
    output h_total, h_active, v_total, v_active, locked, lost
  );

endinterface

// File: rtl/hvsync_decode_sync_edge.sv
// Registers a sync input, normalises it to active-high and flags its leading edge.
module hvsync_decode_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic pclk,
  input  logic reset,
  input  logic sync_in,
  output logic lead
);

  logic s1_q;
  logic prev_q;

  // Input sample plus one-cycle history for edge detection.
  always_ff @(posedge pclk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= sync_in ^ ~POL;
      prev_q <= s1_q;
    end
  end

  assign lead = s1_q & ~prev_q;

endmodule

// File: rtl/hvsync_decode.sv
// Recovers active-area coordinates from hsync/vsync/DE, measures geometry and tracks lock.
module hvsync_decode
  import hvsync_decode_pkg::*;
#(
  parameter int unsigned W           = DefaultW,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic            pclk,
  input logic            reset,
  hvsync_decode_if.slave vid
);

  localparam logic [W-1:0] CntMax     = '1;
  localparam logic [3:0]   LockTarget = 4'(LOCK_FRAMES);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == CntMax) ? v : v + W'(1);
  endfunction

  logic hs_lead, vs_lead;
  logic de_s1_q;

  hvsync_decode_sync_edge #(.POL(HS_POL)) u_hs_edge (
    .pclk    (pclk),
    .reset   (reset),
    .sync_in (vid.hsync_in),
    .lead    (hs_lead)
  );

  hvsync_decode_sync_edge #(.POL(VS_POL)) u_vs_edge (
    .pclk    (pclk),
    .reset   (reset),
    .sync_in (vid.vsync_in),
    .lead    (vs_lead)
  );

  // DE sampled alongside the sync inputs so all three stay aligned.
  always_ff @(posedge pclk) begin
    if (reset) de_s1_q <= 1'b0;
    else       de_s1_q <= vid.de_in;
  end

  // ---------------- Coordinate path ----------------
  logic         h_first_q, v_first_q;
  logic         de_out_q, newline_q, newframe_q;
  logic [W-1:0] hpos_q, vpos_q;
  logic         h_start, v_start;

  // A pending sync edge marks the next DE cycle as the start of a line/frame.
  assign h_start = h_first_q | hs_lead;
  assign v_start = v_first_q | vs_lead;

  // Coordinates advance only on DE cycles and hold outside the active area.
  always_ff @(posedge pclk) begin
    if (reset) begin
      h_first_q  <= 1'b0;
      v_first_q  <= 1'b0;
      de_out_q   <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
      hpos_q     <= '0;
      vpos_q     <= '0;
    end else begin
      de_out_q   <= de_s1_q;
      newline_q  <= de_s1_q & h_start;
      newframe_q <= de_s1_q & h_start & v_start;
      h_first_q  <= de_s1_q ? 1'b0 : h_start;
      v_first_q  <= (de_s1_q && h_start) ? 1'b0 : v_start;
      if (de_s1_q) begin
        hpos_q <= h_start ? '0 : sat_inc(hpos_q);
        if (h_start) vpos_q <= v_start ? '0 : sat_inc(vpos_q);
      end
    end
  end

  // ---------------- Measurement ----------------
  logic [W-1:0] hcnt_q, hcnt_d, dcnt_q, dcnt_d;
  logic [W-1:0] line_len_q, line_len_d, line_act_q, line_act_d;
  logic [W-1:0] lcnt_q, lcnt_d, acnt_q, acnt_d, lcnt_fin, acnt_fin;
  logic [W-1:0] h_total_q, h_active_q, v_total_q, v_active_q;
  logic         line_had_de, publish;

  // A coincident hsync edge is folded into the frame that vsync is closing.
  always_comb begin
    line_had_de = (dcnt_q != '0);
    hcnt_d      = hs_lead ? '0 : sat_inc(hcnt_q);
    line_len_d  = hs_lead ? sat_inc(hcnt_q) : line_len_q;
    line_act_d  = (hs_lead && line_had_de) ? dcnt_q : line_act_q;
    if (hs_lead)      dcnt_d = de_s1_q ? W'(1) : '0;
    else if (de_s1_q) dcnt_d = sat_inc(dcnt_q);
    else              dcnt_d = dcnt_q;
    lcnt_fin = hs_lead ? sat_inc(lcnt_q) : lcnt_q;
    acnt_fin = (hs_lead && line_had_de) ? sat_inc(acnt_q) : acnt_q;
    lcnt_d   = vs_lead ? '0 : lcnt_fin;
    acnt_d   = vs_lead ? '0 : acnt_fin;
  end

  // Running counters plus the published frame geometry.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hcnt_q     <= '0;
      dcnt_q     <= '0;
      line_len_q <= '0;
      line_act_q <= '0;
      lcnt_q     <= '0;
      acnt_q     <= '0;
      h_total_q  <= '0;
      h_active_q <= '0;
      v_total_q  <= '0;
      v_active_q <= '0;
    end else begin
      hcnt_q     <= hcnt_d;
      dcnt_q     <= dcnt_d;
      line_len_q <= line_len_d;
      line_act_q <= line_act_d;
      lcnt_q     <= lcnt_d;
      acnt_q     <= acnt_d;
      if (publish) begin
        h_total_q  <= line_len_d;
        h_active_q <= line_act_d;
        v_total_q  <= lcnt_fin;
        v_active_q <= acnt_fin;
      end
    end
  end

  // ---------------- Lock FSM ----------------
  state_e     state_q, state_d;
  logic [3:0] match_cnt_q, match_cnt_d, match_inc;
  logic       prev_valid_q, prev_valid_d;
  logic       lost_q, lost_d;
  logic       set_equal, wdog;

  // Next state, match counting and lost pulse; the watchdog overrides everything.
  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    prev_valid_d = prev_valid_q;
    lost_d       = 1'b0;
    publish      = 1'b0;
    match_inc    = match_cnt_q + 4'd1;
    set_equal    = prev_valid_q && (line_len_d == h_total_q) && (line_act_d == h_active_q) &&
                   (lcnt_fin == v_total_q) && (acnt_fin == v_active_q);
    wdog         = (hcnt_q == CntMax) || (lcnt_q == CntMax);
    unique case (state_q)
      StSearch: begin
        if (vs_lead) begin
          state_d      = StMeasure;
          match_cnt_d  = '0;
          prev_valid_d = 1'b0;
        end
      end
      StMeasure: begin
        if (vs_lead) begin
          publish      = 1'b1;
          prev_valid_d = 1'b1;
          if (set_equal) begin
            match_cnt_d = match_inc;
            if (match_inc >= LockTarget) state_d = StLocked;
          end else begin
            match_cnt_d = '0;
          end
        end
      end
      StLocked: begin
        if (vs_lead) begin
          publish = 1'b1;
          if (!set_equal) begin
            state_d = StSearch;
            lost_d  = 1'b1;
          end
        end
      end
      default: state_d = StSearch;
    endcase
    if (wdog) begin
      state_d = StSearch;
      lost_d  = (state_q == StLocked);
    end
  end

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= StSearch;
      match_cnt_q  <= '0;
      prev_valid_q <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      prev_valid_q <= prev_valid_d;
      lost_q       <= lost_d;
    end
  end

  assign vid.de_out   = de_out_q;
  assign vid.hpos     = hpos_q;
  assign vid.vpos     = vpos_q;
  assign vid.newline  = newline_q;
  assign vid.newframe = newframe_q;
  assign vid.h_total  = h_total_q;
  assign vid.h_active = h_active_q;
  assign vid.v_total  = v_total_q;
  assign vid.v_active = v_active_q;
  assign vid.locked   = (state_q == StLocked);
  assign vid.lost     = lost_q;

endmodule

// File: tb/tb_hvsync_decode.sv
// Bench for hvsync_decode: a scaled-down panel timing drives an active-high instance and an
// inverted-polarity instance in lockstep; both must give identical results.
module tb_hvsync_decode;
  import hvsync_decode_pkg::*;

  localparam int unsigned W = DefaultW;
  // Scaled geometry keeps lock scenarios short.
  localparam int HT = 64, HA = 48, HS0 = 52, HS1 = 55;
  localparam int VT = 20, VA = 12, VS0 = 14, VS1 = 15;

  typedef struct {
    bit valid;
    int hpos;
    int vpos;
    int nl;
    int nf;
  } exp_t;

  typedef struct {
    int de, hpos, vpos, nl, nf, ht, ha, vt, va, locked, lost;
  } obs_t;

  logic pclk = 1'b0;
  logic reset;
  always #5 pclk = ~pclk;

  hvsync_decode_if #(.W(W)) vif0 ();
  hvsync_decode_if #(.W(W)) vif1 ();

  hvsync_decode #(.W(W), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)) dut0 (
    .pclk  (pclk),
    .reset (reset),
    .vid   (vif0.slave)
  );

  hvsync_decode #(.W(W), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)) dut1 (
    .pclk  (pclk),
    .reset (reset),
    .vid   (vif1.slave)
  );

  int   checks, errors;
  int   cyc, vs_rises, last_hs_cyc;
  bit   seen_vs, vs_prev, hs_prev;
  int   gl, gx, len_line;
  int   lost_cnt[2], lost_cyc[2], nf_cnt[2], nl_cnt[2];
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample(input int d);
    obs_t o;
    if (d == 0) begin
      o.de = int'(vif0.de_out);     o.hpos = int'(vif0.hpos);   o.vpos = int'(vif0.vpos);
      o.nl = int'(vif0.newline);    o.nf = int'(vif0.newframe); o.ht = int'(vif0.h_total);
      o.ha = int'(vif0.h_active);   o.vt = int'(vif0.v_total);  o.va = int'(vif0.v_active);
      o.locked = int'(vif0.locked); o.lost = int'(vif0.lost);
    end else begin
      o.de = int'(vif1.de_out);     o.hpos = int'(vif1.hpos);   o.vpos = int'(vif1.vpos);
      o.nl = int'(vif1.newline);    o.nf = int'(vif1.newframe); o.ht = int'(vif1.h_total);
      o.ha = int'(vif1.h_active);   o.vt = int'(vif1.v_total);  o.va = int'(vif1.v_active);
      o.locked = int'(vif1.locked); o.lost = int'(vif1.lost);
    end
    return o;
  endfunction

  // One pclk: drive inputs, push expectations, clock, then pop/compare DUT output.
  task automatic tick(input bit hs, input bit vs, input bit de, input bit rst,
                      input int ex_h, input int ex_v);
    exp_t e;
    obs_t o;
    reset         = rst;
    vif0.hsync_in = hs;
    vif0.vsync_in = vs;
    vif0.de_in    = de;
    vif1.hsync_in = ~hs;
    vif1.vsync_in = ~vs;
    vif1.de_in    = de;
    if (rst) begin
      q0.delete();
      q1.delete();
      seen_vs  = 1'b0;
      vs_rises = 0;
    end else if (de) begin
      e.valid = seen_vs;
      e.hpos  = ex_h;
      e.vpos  = ex_v;
      e.nl    = (ex_h == 0) ? 1 : 0;
      e.nf    = (ex_h == 0 && ex_v == 0) ? 1 : 0;
      q0.push_back(e);
      q1.push_back(e);
    end
    @(posedge pclk);
    cyc++;
    #1;
    if (!rst) begin
      if (vs && !vs_prev) begin
        vs_rises++;
        seen_vs = 1'b1;
      end
      if (hs && !hs_prev) last_hs_cyc = cyc;
    end
    vs_prev = rst ? 1'b0 : vs;
    hs_prev = rst ? 1'b0 : hs;
    for (int d = 0; d < 2; d++) begin
      o = sample(d);
      if (o.de == 1) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          chk($sformatf("dut%0d sb_underflow", d), 1, 0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          if (e.valid) begin
            chk($sformatf("dut%0d hpos", d), o.hpos, e.hpos);
            chk($sformatf("dut%0d vpos", d), o.vpos, e.vpos);
            chk($sformatf("dut%0d newline", d), o.nl, e.nl);
            chk($sformatf("dut%0d newframe", d), o.nf, e.nf);
          end
        end
      end
      if (o.lost == 1) begin
        lost_cnt[d]++;
        lost_cyc[d] = cyc;
      end
      nf_cnt[d] += o.nf;
      nl_cnt[d] += o.nl;
    end
  endtask

  task automatic stream_step(input bit rst);
    int llen;
    bit hs, vs, de;
    llen = HT + ((gl == len_line) ? 1 : 0);
    hs   = (gx >= HS0 && gx <= HS1);
    vs   = (gl >= VS0 && gl <= VS1);
    de   = (gl < VA && gx < HA);
    tick(hs, vs, de, rst, gx, gl);
    gx++;
    if (gx >= llen) begin
      gx = 0;
      gl = (gl + 1) % VT;
    end
  endtask

  // Stream until n more vsync leading edges have been sampled (bounded).
  task automatic run_until_vs(input int n);
    int target, guard;
    target = vs_rises + n;
    guard  = 0;
    while (vs_rises < target && guard < 2 * VT * (HT + 1) * n) begin
      stream_step(1'b0);
      guard++;
    end
    chk("vs_wait", (vs_rises >= target) ? 1 : 0, 1);
  endtask

  task automatic chk_lock(input string tag, input int locked, input int lost);
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      o = sample(d);
      chk($sformatf("dut%0d %s locked", d, tag), o.locked, locked);
      chk($sformatf("dut%0d %s lost", d, tag), o.lost, lost);
    end
  endtask

  task automatic chk_geom(input string tag, input int ht, input int ha, input int vt,
                          input int va);
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      o = sample(d);
      chk($sformatf("dut%0d %s h_total", d, tag), o.ht, ht);
      chk($sformatf("dut%0d %s h_active", d, tag), o.ha, ha);
      chk($sformatf("dut%0d %s v_total", d, tag), o.vt, vt);
      chk($sformatf("dut%0d %s v_active", d, tag), o.va, va);
    end
  endtask

  task automatic chk_zero(input string tag);
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      o = sample(d);
      chk($sformatf("dut%0d %s de_out", d, tag), o.de, 0);
      chk($sformatf("dut%0d %s hpos", d, tag), o.hpos, 0);
      chk($sformatf("dut%0d %s vpos", d, tag), o.vpos, 0);
      chk($sformatf("dut%0d %s newline", d, tag), o.nl, 0);
      chk($sformatf("dut%0d %s newframe", d, tag), o.nf, 0);
    end
    chk_geom(tag, 0, 0, 0, 0);
    chk_lock(tag, 0, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; vs_rises = 0; last_hs_cyc = 0;
    seen_vs = 1'b0; vs_prev = 1'b0; hs_prev = 1'b0;
    gl = 0; gx = 0; len_line = -1;
    for (int d = 0; d < 2; d++) begin
      lost_cnt[d] = 0; lost_cyc[d] = 0; nf_cnt[d] = 0; nl_cnt[d] = 0;
    end

    // Reset state.
    tick(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk_zero("reset");

    // Fresh acquisition: lock one cycle after the 4th vsync edge.
    run_until_vs(3);
    stream_step(1'b0);
    chk_lock("edge3", 0, 0);
    chk_geom("edge3", HT, HA, VT, VA);
    run_until_vs(1);
    chk_lock("edge4", 0, 0);
    stream_step(1'b0);
    chk_lock("edge4+1", 1, 0);
    chk_geom("locked", HT, HA, VT, VA);

    // One clean frame: one newframe, VA newlines, lock held.
    for (int d = 0; d < 2; d++) begin
      nf_cnt[d] = 0;
      nl_cnt[d] = 0;
    end
    run_until_vs(1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d newframe_count", d), nf_cnt[d], 1);
      chk($sformatf("dut%0d newline_count", d), nl_cnt[d], VA);
      chk($sformatf("dut%0d lost_count0", d), lost_cnt[d], 0);
    end
    stream_step(1'b0);
    chk_lock("clean", 1, 0);

    // Lengthen the last measured line before vsync to HT+1 cycles.
    len_line = VS0 - 2;
    run_until_vs(1);
    len_line = -1;
    stream_step(1'b0);
    chk_lock("long_line", 0, 1);
    chk_geom("long_line", HT + 1, HA, VT, VA);
    stream_step(1'b0);
    chk_lock("long_line+1", 0, 0);
    for (int d = 0; d < 2; d++) chk($sformatf("dut%0d lost_count1", d), lost_cnt[d], 1);
    run_until_vs(3);
    stream_step(1'b0);
    chk_lock("relock3", 0, 0);
    run_until_vs(1);
    stream_step(1'b0);
    chk_lock("relock4", 1, 0);
    chk_geom("relock", HT, HA, VT, VA);

    // Stop all syncs while locked: hcnt watchdog drops lock.
    seen_vs = 1'b0;
    for (int i = 0; i < 4200; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d wdog lost_count", d), lost_cnt[d], 2);
      chk($sformatf("dut%0d wdog lost_cycle", d), lost_cyc[d], last_hs_cyc + 4097);
    end
    chk_lock("wdog", 0, 0);

    // Restart the stream and reset mid-frame inside the active area.
    gl = 0; gx = 0;
    for (int i = 0; i < VT * HT && !(gl == 6 && gx == 20); i++) stream_step(1'b0);
    stream_step(1'b1);
    chk_zero("mid_reset");
    run_until_vs(1);
    stream_step(1'b0);
    chk_lock("rst_edge1", 0, 0);
    chk_geom("rst_edge1", 0, 0, 0, 0);
    run_until_vs(1);
    stream_step(1'b0);
    chk_lock("rst_edge2", 0, 0);
    chk_geom("rst_edge2", HT, HA, VT, VA);
    run_until_vs(1);
    stream_step(1'b0);
    chk_lock("rst_edge3", 0, 0);
    run_until_vs(1);
    chk_lock("rst_edge4", 0, 0);
    stream_step(1'b0);
    chk_lock("rst_edge4+1", 1, 0);
    chk_geom("rst_locked", HT, HA, VT, VA);
    for (int d = 0; d < 2; d++) chk($sformatf("dut%0d final lost_count", d), lost_cnt[d], 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
